// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   state_e       : arbiter FSM states
//   M_CPU / M_DMA : master ids as used for grant and last_grant
//   TIMEOUT_RDATA : read data returned when the watchdog fires
//   pick_winner   : tie-break between the two candidate masters
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StTimeout = 2'd2
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // Only meaningful when at least one candidate is set.
  function automatic logic pick_winner(input logic cand0, input logic cand1,
                                       input logic last_grant, input bit fixed_priority);
    if (cand0 && cand1) begin
      return fixed_priority ? M_CPU : ~last_grant;
    end
    return cand0 ? M_CPU : M_DMA;
  endfunction

endpackage

// File: rtl/mem_arbiter_port.sv
// Per-master request capture for mem_arbiter.
// Holds one pending transaction for a master that could not be granted at
// once and flags protocol violations (a new request while one is pending or
// in flight).
// Ports:
//   clock, reset        : clock, synchronous active-low reset
//   request, address,
//   write, wstrb, wdata : master request pulse and its fields
//   in_flight           : this master currently owns the slave
//   take                : the arbiter grants this master's candidate this edge
//   cand_valid, cand_*  : candidate transaction (pending one, else the live pulse)
//   overrun             : sticky protocol-violation flag
module mem_arbiter_port
  import mem_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        request,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        in_flight,
  input  logic        take,
  output logic        cand_valid,
  output logic [31:0] cand_address,
  output logic        cand_write,
  output logic [3:0]  cand_wstrb,
  output logic [31:0] cand_wdata,
  output logic        overrun
);

  logic        pend_valid_q;
  logic [31:0] pend_address_q;
  logic        pend_write_q;
  logic [3:0]  pend_wstrb_q;
  logic [31:0] pend_wdata_q;
  logic        overrun_q;
  logic        ignore;

  assign ignore = request && (pend_valid_q || in_flight);

  // A live pulse is a candidate in its own cycle so an idle arbiter can grant
  // it without a capture cycle; a pulse from the in-flight master never is.
  assign cand_valid   = pend_valid_q || (request && !in_flight);
  assign cand_address = pend_valid_q ? pend_address_q : address;
  assign cand_write   = pend_valid_q ? pend_write_q   : write;
  assign cand_wstrb   = pend_valid_q ? pend_wstrb_q   : wstrb;
  assign cand_wdata   = pend_valid_q ? pend_wdata_q   : wdata;
  assign overrun      = overrun_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_valid_q   <= 1'b0;
      pend_address_q <= '0;
      pend_write_q   <= 1'b0;
      pend_wstrb_q   <= '0;
      pend_wdata_q   <= '0;
      overrun_q      <= 1'b0;
    end else begin
      if (ignore) begin
        overrun_q <= 1'b1;
      end
      if (take) begin
        pend_valid_q <= 1'b0;
      end else if (request && !ignore) begin
        pend_valid_q   <= 1'b1;
        pend_address_q <= address;
        pend_write_q   <= write;
        pend_wstrb_q   <= wstrb;
        pend_wdata_q   <= wdata;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: cpu (m0) and DMA (m1) share one slave port.
// Request pulses are captured per master, one master is granted at a time
// (round-robin or fixed cpu priority), the transaction is forwarded as a
// one-cycle mem_request with held fields, and the slave ack is routed back
// combinationally. A watchdog answers with TIMEOUT_RDATA if the slave stalls.
// Ports:
//   clock, reset       : clock, synchronous active-low reset
//   m0_*/m1_*          : master request pulse + fields in, rdata/ack out
//   mem_*              : slave request pulse + held fields out, rdata/ack in
//   timeout_count      : saturating count of watchdog events
//   overrun            : sticky per-master protocol-violation flags
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_request,
  input  logic [31:0] m0_address,
  input  logic        m0_write,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_request,
  input  logic [31:0] m1_address,
  input  logic        m1_write,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  timeout_count,
  output logic [1:0]  overrun
);

  // Watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle without an ack.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [7:0]  wd_q;
  logic [7:0]  timeout_count_q;
  logic        mem_request_q;
  logic [31:0] mem_address_q;
  logic        mem_write_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;

  logic        c0_valid, c1_valid;
  logic [31:0] c0_address, c1_address;
  logic        c0_write, c1_write;
  logic [3:0]  c0_wstrb, c1_wstrb;
  logic [31:0] c0_wdata, c1_wdata;
  logic        ovr0, ovr1;

  logic        in_flight0, in_flight1;
  logic        arb_open;
  logic        grant_now;
  logic        winner;
  logic        take0, take1;
  logic        resp_valid;
  logic [31:0] resp_data;

  assign in_flight0 = (state_q != StIdle) && (grant_q == M_CPU);
  assign in_flight1 = (state_q != StIdle) && (grant_q == M_DMA);

  // The ack cycle is also a grant opportunity so a waiting master gets its
  // mem_request in the very next cycle (back-to-back).
  assign arb_open  = (state_q == StIdle) || ((state_q == StBusy) && mem_ack);
  assign winner    = pick_winner(c0_valid, c1_valid, last_grant_q, FIXED_PRIORITY);
  assign grant_now = arb_open && (c0_valid || c1_valid);
  assign take0     = grant_now && (winner == M_CPU);
  assign take1     = grant_now && (winner == M_DMA);

  mem_arbiter_port u_port_m0 (
    .clock        (clock),
    .reset        (reset),
    .request      (m0_request),
    .address      (m0_address),
    .write        (m0_write),
    .wstrb        (m0_wstrb),
    .wdata        (m0_wdata),
    .in_flight    (in_flight0),
    .take         (take0),
    .cand_valid   (c0_valid),
    .cand_address (c0_address),
    .cand_write   (c0_write),
    .cand_wstrb   (c0_wstrb),
    .cand_wdata   (c0_wdata),
    .overrun      (ovr0)
  );

  mem_arbiter_port u_port_m1 (
    .clock        (clock),
    .reset        (reset),
    .request      (m1_request),
    .address      (m1_address),
    .write        (m1_write),
    .wstrb        (m1_wstrb),
    .wdata        (m1_wdata),
    .in_flight    (in_flight1),
    .take         (take1),
    .cand_valid   (c1_valid),
    .cand_address (c1_address),
    .cand_write   (c1_write),
    .cand_wstrb   (c1_wstrb),
    .cand_wdata   (c1_wdata),
    .overrun      (ovr1)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= StIdle;
      grant_q         <= M_CPU;
      last_grant_q    <= M_DMA;
      wd_q            <= '0;
      timeout_count_q <= '0;
      mem_request_q   <= 1'b0;
      mem_address_q   <= '0;
      mem_write_q     <= 1'b0;
      mem_wstrb_q     <= '0;
      mem_wdata_q     <= '0;
    end else begin
      mem_request_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
        StBusy: begin
          if (mem_ack) begin
            state_q <= StIdle;
          end else if (wd_q == WD_LAST) begin
            state_q <= StTimeout;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        StTimeout: begin
          if (timeout_count_q != 8'hFF) begin
            timeout_count_q <= timeout_count_q + 8'd1;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
      // A new grant overrides the completion transition above.
      if (grant_now) begin
        state_q       <= StBusy;
        grant_q       <= winner;
        last_grant_q  <= winner;
        wd_q          <= '0;
        mem_request_q <= 1'b1;
        mem_address_q <= (winner == M_DMA) ? c1_address : c0_address;
        mem_write_q   <= (winner == M_DMA) ? c1_write   : c0_write;
        mem_wstrb_q   <= (winner == M_DMA) ? c1_wstrb   : c0_wstrb;
        mem_wdata_q   <= (winner == M_DMA) ? c1_wdata   : c0_wdata;
      end
    end
  end

  // Responses are gated by reset so an ack racing a reset never reaches a master.
  always_comb begin
    resp_valid = reset && (((state_q == StBusy) && mem_ack) || (state_q == StTimeout));
    resp_data  = (state_q == StTimeout) ? TIMEOUT_RDATA : mem_rdata;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    if (resp_valid) begin
      if (grant_q == M_CPU) begin
        m0_ack   = 1'b1;
        m0_rdata = resp_data;
      end else begin
        m1_ack   = 1'b1;
        m1_rdata = resp_data;
      end
    end
  end

  assign mem_request   = mem_request_q;
  assign mem_address   = mem_address_q;
  assign mem_write     = mem_write_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_wdata     = mem_wdata_q;
  assign timeout_count = timeout_count_q;
  assign overrun       = {ovr1, ovr0};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; a transaction-level model predicts every output each
// cycle, and directed literal checks pin the model at key cycles.
module tb_mem_arbiter;

  localparam int TC = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0]       wr;
  logic [1:0][3:0]  strb;
  logic [1:0][31:0] wdat;
  logic             mem_ack;
  logic [31:0]      mem_rdata;

  // Outputs indexed [dut][master]; dut 0 = round-robin, dut 1 = fixed priority.
  logic [1:0][1:0][31:0] rdata_o;
  logic [1:0][1:0]       ack_o;
  logic [1:0]            mreq_o;
  logic [1:0][31:0]      maddr_o;
  logic [1:0]            mwr_o;
  logic [1:0][3:0]       mstrb_o;
  logic [1:0][31:0]      mwdata_o;
  logic [1:0][7:0]       tcnt_o;
  logic [1:0][1:0]       ovr_o;

  mem_arbiter #(.TIMEOUT_CYCLES(TC), .FIXED_PRIORITY(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .m0_request(req[0]), .m0_address(addr[0]), .m0_write(wr[0]), .m0_wstrb(strb[0]),
    .m0_wdata(wdat[0]), .m0_rdata(rdata_o[0][0]), .m0_ack(ack_o[0][0]),
    .m1_request(req[1]), .m1_address(addr[1]), .m1_write(wr[1]), .m1_wstrb(strb[1]),
    .m1_wdata(wdat[1]), .m1_rdata(rdata_o[0][1]), .m1_ack(ack_o[0][1]),
    .mem_request(mreq_o[0]), .mem_address(maddr_o[0]), .mem_write(mwr_o[0]),
    .mem_wstrb(mstrb_o[0]), .mem_wdata(mwdata_o[0]), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .timeout_count(tcnt_o[0]), .overrun(ovr_o[0])
  );

  mem_arbiter #(.TIMEOUT_CYCLES(TC), .FIXED_PRIORITY(1'b1)) u_fx (
    .clock(clock), .reset(reset),
    .m0_request(req[0]), .m0_address(addr[0]), .m0_write(wr[0]), .m0_wstrb(strb[0]),
    .m0_wdata(wdat[0]), .m0_rdata(rdata_o[1][0]), .m0_ack(ack_o[1][0]),
    .m1_request(req[1]), .m1_address(addr[1]), .m1_write(wr[1]), .m1_wstrb(strb[1]),
    .m1_wdata(wdat[1]), .m1_rdata(rdata_o[1][1]), .m1_ack(ack_o[1][1]),
    .mem_request(mreq_o[1]), .mem_address(maddr_o[1]), .mem_write(mwr_o[1]),
    .mem_wstrb(mstrb_o[1]), .mem_wdata(mwdata_o[1]), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .timeout_count(tcnt_o[1]), .overrun(ovr_o[1])
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // ph: 0 = no owner, 1 = waiting on slave, 2 = watchdog answer cycle
  int          ph[2], own[2], lst[2], waited[2], tcnt[2];
  bit          pv[2][2], pw[2][2], ov[2][2];
  logic [31:0] pa[2][2], pd[2][2];
  logic [3:0]  ps[2][2];
  bit          e_req[2], e_wr[2];
  logic [31:0] e_addr[2], e_wdata[2];
  logic [3:0]  e_strb[2];

  task automatic model_step(input int d);
    bit inflight[2];
    bit cand[2];
    bit ign[2];
    bit open_arb;
    int win;
    if (!reset) begin
      ph[d] = 0; own[d] = 0; lst[d] = 1; waited[d] = 0; tcnt[d] = 0;
      e_req[d] = 0; e_wr[d] = 0; e_addr[d] = 0; e_wdata[d] = 0; e_strb[d] = 0;
      for (int m = 0; m < 2; m++) begin
        pv[d][m] = 0; ov[d][m] = 0;
      end
      return;
    end
    for (int m = 0; m < 2; m++) begin
      inflight[m] = (ph[d] != 0) && (own[d] == m);
      ign[m]      = req[m] && (pv[d][m] || inflight[m]);
      cand[m]     = pv[d][m] || (req[m] && !inflight[m]);
      if (ign[m]) ov[d][m] = 1;
    end
    open_arb = (ph[d] == 0) || (ph[d] == 1 && mem_ack);
    e_req[d] = 0;
    if (ph[d] == 2) begin
      tcnt[d] = (tcnt[d] < 255) ? tcnt[d] + 1 : 255;
      ph[d] = 0;
    end else if (ph[d] == 1) begin
      if (mem_ack) ph[d] = 0;
      else begin
        waited[d]++;
        if (waited[d] == TC) ph[d] = 2;
      end
    end
    win = -1;
    if (open_arb && (cand[0] || cand[1])) begin
      if (cand[0] && cand[1]) win = (d == 1) ? 0 : 1 - lst[d];
      else win = cand[0] ? 0 : 1;
      e_addr[d]  = pv[d][win] ? pa[d][win] : addr[win];
      e_wr[d]    = pv[d][win] ? pw[d][win] : wr[win];
      e_strb[d]  = pv[d][win] ? ps[d][win] : strb[win];
      e_wdata[d] = pv[d][win] ? pd[d][win] : wdat[win];
      e_req[d] = 1; ph[d] = 1; own[d] = win; lst[d] = win; waited[d] = 0;
      pv[d][win] = 0;
    end
    for (int m = 0; m < 2; m++) begin
      if (m != win && req[m] && !ign[m]) begin
        pv[d][m] = 1; pa[d][m] = addr[m]; pw[d][m] = wr[m];
        ps[d][m] = strb[m]; pd[d][m] = wdat[m];
      end
    end
  endtask

  function automatic logic exp_ack(input int d, input int m);
    return reset && (own[d] == m) && ((ph[d] == 1 && mem_ack) || ph[d] == 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input int d, input int m);
    if (!exp_ack(d, m)) return 32'h0;
    return (ph[d] == 2) ? 32'hDEADBEEF : mem_rdata;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("d%0d_m%0d_ack", d, m), 32'(ack_o[d][m]), 32'(exp_ack(d, m)));
          chk($sformatf("d%0d_m%0d_rdata", d, m), rdata_o[d][m], exp_rdata(d, m));
        end
        chk($sformatf("d%0d_mem_request", d), 32'(mreq_o[d]), 32'(e_req[d]));
        chk($sformatf("d%0d_mem_address", d), maddr_o[d], e_addr[d]);
        chk($sformatf("d%0d_mem_write", d), 32'(mwr_o[d]), 32'(e_wr[d]));
        chk($sformatf("d%0d_mem_wstrb", d), 32'(mstrb_o[d]), 32'(e_strb[d]));
        chk($sformatf("d%0d_mem_wdata", d), mwdata_o[d], e_wdata[d]);
        chk($sformatf("d%0d_timeout_count", d), 32'(tcnt_o[d]), 32'(tcnt[d]));
        chk($sformatf("d%0d_overrun", d), 32'(ovr_o[d]), 32'({ov[d][1], ov[d][0]}));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    req       = '0;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] dt);
    req[m] = 1'b1; addr[m] = a; wr[m] = w; strb[m] = s; wdat[m] = dt;
  endtask

  task automatic ack_now(input logic [31:0] dt);
    mem_ack = 1'b1; mem_rdata = dt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = '0; addr = '0; wr = '0; strb = '0; wdat = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    idle(2);
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_mem_request", 32'(mreq_o[0]), 32'h0);
    chk("reset_overrun", 32'(ovr_o[0]), 32'h0);
    reset = 1'b1;
    idle(1);

    // 1: m0 read, slave acks in the third BUSY cycle.
    set_req(0, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
    tick();
    @(negedge clock);
    chk("t1_mem_request", 32'(mreq_o[0]), 32'h1);
    chk("t1_mem_address", maddr_o[0], 32'h0000_1000);
    tick();
    @(negedge clock);
    chk("t1_mem_request_drop", 32'(mreq_o[0]), 32'h0);
    tick();
    ack_now(32'h1234_5678);
    @(negedge clock);
    chk("t1_m0_ack", 32'(ack_o[0][0]), 32'h1);
    chk("t1_m0_rdata", rdata_o[0][0], 32'h1234_5678);
    chk("t1_m1_ack", 32'(ack_o[0][1]), 32'h0);
    tick();
    idle(1);

    // 2: ties. From reset m0 wins, m1 follows back-to-back.
    do_reset();
    set_req(0, 32'h0000_3000, 1'b0, 4'h0, 32'h0);
    set_req(1, 32'h0000_4000, 1'b1, 4'hF, 32'h0000_55AA);
    tick();
    @(negedge clock);
    chk("t2_rr_first", maddr_o[0], 32'h0000_3000);
    chk("t2_fx_first", maddr_o[1], 32'h0000_3000);
    tick();
    ack_now(32'hA0A0_A0A0);
    @(negedge clock);
    chk("t2_m0_ack", 32'(ack_o[0][0]), 32'h1);
    tick();
    @(negedge clock);
    chk("t2_b2b_request", 32'(mreq_o[0]), 32'h1);
    chk("t2_b2b_address", maddr_o[0], 32'h0000_4000);
    tick();
    ack_now(32'hB1B1_B1B1);
    @(negedge clock);
    chk("t2_m1_rdata", rdata_o[0][1], 32'hB1B1_B1B1);
    tick();
    set_req(0, 32'h0000_3004, 1'b0, 4'h0, 32'h0);
    set_req(1, 32'h0000_4004, 1'b0, 4'h0, 32'h0);
    tick();
    @(negedge clock);
    chk("t2_rr_second_tie", maddr_o[0], 32'h0000_3004);
    tick();
    ack_now(32'h1);
    tick();
    tick();
    ack_now(32'h2);
    tick();
    set_req(0, 32'h0000_3010, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    ack_now(32'h3);
    tick();
    // last grant is now m0: round-robin picks m1, fixed priority keeps m0.
    set_req(0, 32'h0000_3008, 1'b0, 4'h0, 32'h0);
    set_req(1, 32'h0000_4008, 1'b0, 4'h0, 32'h0);
    tick();
    @(negedge clock);
    chk("t2_rr_third_tie", maddr_o[0], 32'h0000_4008);
    chk("t2_fx_third_tie", maddr_o[1], 32'h0000_3008);
    tick();
    ack_now(32'h4);
    tick();
    tick();
    ack_now(32'h5);
    tick();
    idle(1);

    // 3: m1 write held stable until the ack.
    set_req(1, 32'h0000_2000, 1'b1, 4'b0011, 32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ack_now(32'h0);
      @(negedge clock);
      chk("t3_mem_write", 32'(mwr_o[0]), 32'h1);
      chk("t3_mem_wstrb", 32'(mstrb_o[0]), 32'h3);
      chk("t3_mem_wdata", mwdata_o[0], 32'hCAFE_F00D);
      tick();
    end
    idle(1);

    // 4: slave never acks; acks during TIMEOUT and after are dropped.
    set_req(0, 32'h0000_5000, 1'b0, 4'h0, 32'h0);
    tick();
    idle(TC - 1);
    @(negedge clock);
    chk("t4_no_early_ack", 32'(ack_o[0][0]), 32'h0);
    tick();
    ack_now(32'h1111_1111);
    @(negedge clock);
    chk("t4_timeout_ack", 32'(ack_o[0][0]), 32'h1);
    chk("t4_timeout_rdata", rdata_o[0][0], 32'hDEADBEEF);
    tick();
    ack_now(32'h2222_2222);
    @(negedge clock);
    chk("t4_late_ack_m0", 32'(ack_o[0][0]), 32'h0);
    chk("t4_late_ack_m1", 32'(ack_o[0][1]), 32'h0);
    chk("t4_timeout_count", 32'(tcnt_o[0]), 32'h1);
    tick();
    set_req(1, 32'h0000_6000, 1'b0, 4'h0, 32'h0);
    tick();
    @(negedge clock);
    chk("t4_next_address", maddr_o[0], 32'h0000_6000);
    tick();
    ack_now(32'h0000_0077);
    @(negedge clock);
    chk("t4_next_rdata", rdata_o[0][1], 32'h0000_0077);
    tick();
    idle(1);

    // 5: second m0 request while the first is in flight.
    set_req(0, 32'h0000_7000, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    set_req(0, 32'h0000_7100, 1'b0, 4'h0, 32'h0);
    tick();
    ack_now(32'h0);
    @(negedge clock);
    chk("t5_overrun", 32'(ovr_o[0]), 32'h1);
    tick();
    @(negedge clock);
    chk("t5_single_request", 32'(mreq_o[0]), 32'h0);
    tick();

    // 6: reset during BUSY, then a stray ack.
    set_req(0, 32'h0000_8000, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ack_now(32'h0000_0099);
    @(negedge clock);
    chk("t6_no_ack", 32'(ack_o[0][0]), 32'h0);
    chk("t6_address_cleared", maddr_o[0], 32'h0);
    chk("t6_overrun_cleared", 32'(ovr_o[0]), 32'h0);
    chk("t6_tcount_cleared", 32'(tcnt_o[0]), 32'h0);
    tick();
    set_req(1, 32'h0000_9000, 1'b0, 4'h0, 32'h0);
    tick();
    @(negedge clock);
    chk("t6_m1_address", maddr_o[0], 32'h0000_9000);
    tick();
    ack_now(32'h0000_ABCD);
    @(negedge clock);
    chk("t6_m1_ack", 32'(ack_o[0][1]), 32'h1);
    chk("t6_m1_rdata", rdata_o[0][1], 32'h0000_ABCD);
    tick();
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
